// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard transmitter:
//   FRAME_BITS            - bits per PS/2 device-to-host frame (11)
//   BIT_START/PARITY/STOP - bit-index constants within a frame
//   state_t               - transmitter states (IDLE, SEND, GAP)
//   phase_t               - half of a bit period (clock high / clock low)
//   make_frame()          - packs a scan-code byte into an 11-bit frame
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    localparam logic [3:0] BIT_START  = 4'd0;
    localparam logic [3:0] BIT_PARITY = 4'd9;
    localparam logic [3:0] BIT_STOP   = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    // First half of each bit holds the clock released, second half pulls it low.
    typedef enum logic {
        PH_HIGH,
        PH_LOW
    } phase_t;

    // Frame bit i is transmitted i-th: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        logic [FRAME_BITS-1:0] frame;
        frame             = '1;
        frame[BIT_START]  = 1'b0;
        frame[8:1]        = data;
        frame[BIT_PARITY] = ~^data;
        frame[BIT_STOP]   = 1'b1;
        return frame;
    endfunction

endpackage

// File: rtl/ps2tx_fifo.sv
// ----------------------------------------------------------------------------
// ps2tx_fifo
// Synchronous byte queue with registered full/empty flags and a show-ahead
// head output (rd_data is the oldest entry whenever empty is low).
// Ports:
//   clk_sys  in   system clock, rising edge
//   reset    in   synchronous active-high reset (empties the queue)
//   push     in   write request; taken only while wr_ready is high
//   wr_data  in   WIDTH-bit entry to write
//   wr_ready out  queue not full (low during reset)
//   pop      in   remove head entry; ignored while empty
//   rd_data  out  head entry
//   empty    out  queue holds no entries
// Parameters: DEPTH (power of two, >= 2), WIDTH.
// ----------------------------------------------------------------------------
module ps2tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             ready_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Flags are registered from the next count, so they are valid on the
    // cycle right after any push/pop. ready_q resets low so the writer sees
    // "not ready" for as long as reset is held.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem[rptr_q];
    assign wr_ready = ready_q;
    assign empty    = empty_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// ----------------------------------------------------------------------------
// ps2_kbd_tx
// PS/2 keyboard (device-to-host) transmitter. Bytes are queued, then each is
// sent as an 11-bit frame; every bit is a clock-high half followed by a
// clock-low half of CLK_DIV cycles each. After a frame the lines stay released
// for GAP_BITS bit periods before the next frame may start.
// Ports:
//   clk_sys   in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   tx_data   in   scan-code byte
//   tx_valid  in   byte offered; accepted when tx_valid && tx_ready
//   tx_ready  out  queue not full
//   ps2_clk_i in   sensed PS/2 clock line (host inhibit)
//   ps2_clk_o out  PS/2 clock drive, 1 = released
//   ps2_dat_o out  PS/2 data drive, 1 = released
//   busy      out  frame or gap in progress, or queue non-empty
// Parameters: CLK_DIV (cycles per half bit), GAP_BITS (idle bits between
// frames), FIFO_DEPTH (queue depth, power of two >= 2).
// Build option: define PS2TX_INHIBIT_EN to let the host abort a frame by
// holding the clock low; the aborted byte is resent from its start bit.
// Without it ps2_clk_i is ignored.
// ----------------------------------------------------------------------------
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 1103,
    parameter int GAP_BITS   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_o,
    output logic       ps2_dat_o,
    output logic       busy
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [3:0]             bit_q, bit_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;

    logic       div_last;
    logic       pop;
    logic [7:0] head;
    logic       empty;
    logic       aborted;
    logic       send_active;

    ps2tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .push     (tx_valid),
        .wr_data  (tx_data),
        .wr_ready (tx_ready),
        .pop      (pop),
        .rd_data  (head),
        .empty    (empty)
    );

`ifdef PS2TX_INHIBIT_EN
    // Host clock line is asynchronous to clk_sys; the line idles high.
    logic [1:0] sync_q;
    logic       clk_high;
    logic       abort_q, abort_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_q  <= 2'b11;
            abort_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], ps2_clk_i};
            abort_q <= abort_d;
        end
    end

    assign clk_high = sync_q[1];
    assign aborted  = abort_q;
`else
    logic unused_clk_in;
    assign unused_clk_in = ps2_clk_i;
    assign aborted       = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= PH_HIGH;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            frame_q <= '1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
        end
    end

    assign div_last = (div_q == DIV_LAST);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        pop     = 1'b0;
`ifdef PS2TX_INHIBIT_EN
        abort_d = abort_q;
`endif

        case (state_q)
            IDLE: begin
                // The frame is captured here so the head byte can stay in the
                // queue until the stop bit has fully gone out.
                if (!empty) begin
                    state_d = SEND;
                    phase_d = PH_HIGH;
                    bit_d   = BIT_START;
                    div_d   = '0;
                    frame_d = make_frame(head);
                end
            end

            SEND: begin
`ifdef PS2TX_INHIBIT_EN
                if (abort_q) begin
                    // Lines released; wait for the host to let go of the clock.
                    if (clk_high) begin
                        state_d = GAP;
                        gap_d   = '0;
                        abort_d = 1'b0;
                    end
                end else if (phase_q == PH_HIGH && !clk_high) begin
                    // Host holds the clock low while we have it released.
                    abort_d = 1'b1;
                    phase_d = PH_HIGH;
                    bit_d   = BIT_START;
                    div_d   = '0;
                end else
`endif
                begin
                    if (div_last) begin
                        div_d = '0;
                        if (phase_q == PH_HIGH) begin
                            phase_d = PH_LOW;
                        end else begin
                            phase_d = PH_HIGH;
                            if (bit_q == BIT_STOP) begin
                                state_d = GAP;
                                gap_d   = '0;
                                bit_d   = BIT_START;
                                pop     = 1'b1;
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data follows the bit counter, which only advances into a clock-high
    // half, so the data line changes only on the first cycle of that half.
    assign send_active = (state_q == SEND) && !aborted;
    assign ps2_clk_o   = !(send_active && phase_q == PH_LOW);
    assign ps2_dat_o   = send_active ? frame_q[bit_q] : 1'b1;
    assign busy        = (state_q != IDLE) || !empty;

endmodule
